// File: rtl/voice_mix_dac_if.sv
// Signal bundle between the voice mixer/DAC shifter and its surroundings.
// The master side drives voices, gains and ticks; the slave side is the mixer.
interface voice_mix_dac_if;
  logic [15:0] voice0, voice1, voice2;
  logic [7:0]  gain0, gain1, gain2;
  logic        mute;
  logic        sample_tick;
  logic [15:0] sample_out;
  logic        DAC_CS;
  logic        DAC_SCK;
  logic        DAC_MOSI;
  logic        busy;
  logic        overrun;

  modport master (
    output voice0, voice1, voice2, gain0, gain1, gain2, mute, sample_tick,
    input  sample_out, DAC_CS, DAC_SCK, DAC_MOSI, busy, overrun
  );

  modport slave (
    input  voice0, voice1, voice2, gain0, gain1, gain2, mute, sample_tick,
    output sample_out, DAC_CS, DAC_SCK, DAC_MOSI, busy, overrun
  );
endinterface

// File: rtl/voice_mix_dac.sv
// Three-voice gain mixer with 16-bit saturation feeding a 24-bit serial DAC frame.
// One frame per sample tick: capture, 3-cycle MAC, saturate, shift out, CS gap.
module voice_mix_dac #(
  parameter int         SCLK_DIV   = 4,
  parameter logic [7:0] CMD_BYTE   = 8'h30,
  parameter int         GAP_CYCLES = 8
) (
  input  logic           clk,
  input  logic           rst,
  voice_mix_dac_if.slave bus
);
  typedef enum logic [2:0] {IDLE, MAC, SAT, SHIFT, GAP} state_e;

  localparam logic [15:0] DIV_LAST = 16'(SCLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic signed [25:0] acc_q, acc_d;
  logic [15:0]        div_q, div_d;
  logic [15:0]        gap_q, gap_d;
  logic [4:0]         bit_q, bit_d;
  logic               cs_q, cs_d;
  logic               sck_q, sck_d;
  logic               mosi_q, mosi_d;
  logic               ovr_q, ovr_d;
  logic [15:0]        sample_q, sample_d;
  logic [23:0]        frame_q, frame_d;

  logic [15:0]        v0_q, v1_q, v2_q;
  logic [7:0]         g0_q, g1_q, g2_q;
  logic               mute_q;
  logic               capture;
  logic [15:0]        cur_v;
  logic [7:0]         cur_g;
  logic [15:0]        sat_w;

  // Offset-binary voice times unsigned gain, as a signed 25-bit product.
  function automatic logic signed [24:0] mac_term(input logic [15:0] v, input logic [7:0] g);
    logic signed [24:0] s;
    logic signed [24:0] gs;
    s  = {{9{~v[15]}}, ~v[15], v[14:0]};
    gs = {17'd0, g};
    return s * gs;
  endfunction

  // Drop the 7 fractional gain bits (floor), clamp to 16 bits, return offset binary.
  function automatic logic [15:0] sat_offset(input logic signed [25:0] acc, input logic mute);
    logic signed [25:0] r;
    logic [15:0]        c;
    r = acc >>> 7;
    if (mute)                   c = 16'h0000;
    else if (r > 26'sd32767)    c = 16'h7FFF;
    else if (r < -26'sd32768)   c = 16'h8000;
    else                        c = r[15:0];
    return {~c[15], c[14:0]};
  endfunction

  always_comb begin
    cur_v = v2_q;
    cur_g = g2_q;
    case (idx_q)
      2'd0:    begin cur_v = v0_q; cur_g = g0_q; end
      2'd1:    begin cur_v = v1_q; cur_g = g1_q; end
      default: begin cur_v = v2_q; cur_g = g2_q; end
    endcase
  end

  assign sat_w = sat_offset(acc_q, mute_q);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    div_d    = div_q;
    gap_d    = gap_q;
    bit_d    = bit_q;
    cs_d     = cs_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    sample_d = sample_q;
    frame_d  = frame_q;
    capture  = 1'b0;
    ovr_d    = ovr_q | (bus.sample_tick && (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (bus.sample_tick) begin
          capture = 1'b1;
          acc_d   = '0;
          idx_d   = 2'd0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + 26'(mac_term(cur_v, cur_g));
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd2) state_d = SAT;
      end
      SAT: begin
        frame_d  = {CMD_BYTE, sat_w};
        sample_d = sat_w;
        cs_d     = 1'b0;
        sck_d    = 1'b0;
        mosi_d   = CMD_BYTE[7];
        div_d    = '0;
        bit_d    = '0;
        state_d  = SHIFT;
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else if (bit_q == 5'd23) begin
            sck_d   = 1'b0;
            cs_d    = 1'b1;
            mosi_d  = 1'b0;
            gap_d   = '0;
            state_d = GAP;
          end else begin
            // Next bit launches on the SCK falling edge.
            sck_d  = 1'b0;
            bit_d  = bit_q + 5'd1;
            mosi_d = frame_q[5'd22 - bit_q];
          end
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      div_q    <= '0;
      gap_q    <= '0;
      bit_q    <= '0;
      cs_q     <= 1'b1;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      ovr_q    <= 1'b0;
      sample_q <= 16'h8000;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      div_q    <= div_d;
      gap_q    <= gap_d;
      bit_q    <= bit_d;
      cs_q     <= cs_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      ovr_q    <= ovr_d;
      sample_q <= sample_d;
    end
  end

  // Captured operands and the shift frame carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    frame_q <= frame_d;
    if (capture) begin
      v0_q   <= bus.voice0;
      v1_q   <= bus.voice1;
      v2_q   <= bus.voice2;
      g0_q   <= bus.gain0;
      g1_q   <= bus.gain1;
      g2_q   <= bus.gain2;
      mute_q <= bus.mute;
    end
  end

  assign bus.sample_out = sample_q;
  assign bus.DAC_CS     = cs_q;
  assign bus.DAC_SCK    = sck_q;
  assign bus.DAC_MOSI   = mosi_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_voice_mix_dac.sv
// Bench for voice_mix_dac: directed mixes, random mixes against an arithmetic
// model, overrun behaviour and reset in the middle of a frame.
module tb_voice_mix_dac;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  voice_mix_dac_if bus();

  voice_mix_dac #(.SCLK_DIV(4), .CMD_BYTE(8'h30), .GAP_CYCLES(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // Mixed sample from plain integer arithmetic: signed voice value times gain/128, floored.
  function automatic logic [15:0] model_mix(input logic [15:0] v0, v1, v2,
                                            input logic [7:0] g0, g1, g2, input logic m);
    int sum, r;
    if (m) return 16'h8000;
    sum = (int'(v0) - 32768) * int'(g0) + (int'(v1) - 32768) * int'(g1)
        + (int'(v2) - 32768) * int'(g2);
    r = sum / 128;
    if (sum < 0 && (sum % 128) != 0) r = r - 1;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return 16'(r + 32768);
  endfunction

  task automatic rand_inputs;
    bus.voice0 = 16'($urandom); bus.voice1 = 16'($urandom); bus.voice2 = 16'($urandom);
    bus.gain0  = 8'($urandom);  bus.gain1  = 8'($urandom);  bus.gain2  = 8'($urandom);
    bus.mute   = 1'($urandom);
  endtask

  // Issues one tick and watches the bus until busy drops, optionally with a second tick at cycle extra_at.
  task automatic run_frame(input logic [15:0] v0, v1, v2, input logic [7:0] g0, g1, g2,
                           input logic m, input int extra_at,
                           output logic [23:0] bits, output int nbits, output int fall_at,
                           output int low_cnt, output int falls, output int period,
                           output int glitches, output logic [15:0] so);
    logic prev_sck, prev_cs, prev_mosi;
    bits = '0; nbits = 0; fall_at = -1; low_cnt = 0; falls = 0; period = -1; glitches = 0;
    so = 16'hxxxx;
    prev_sck = 1'b0; prev_cs = 1'b1; prev_mosi = 1'b0;
    bus.voice0 = v0; bus.voice1 = v1; bus.voice2 = v2;
    bus.gain0 = g0; bus.gain1 = g1; bus.gain2 = g2; bus.mute = m;
    bus.sample_tick = 1'b1;
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      @(negedge clk);
      if (!bus.DAC_CS) begin
        low_cnt++;
        if (prev_cs) begin
          falls++;
          if (fall_at < 0) begin fall_at = cyc; so = bus.sample_out; end
        end else if (bus.DAC_MOSI !== prev_mosi && !(prev_sck && !bus.DAC_SCK)) begin
          glitches++;
        end
        if (!prev_sck && bus.DAC_SCK) begin bits = {bits[22:0], bus.DAC_MOSI}; nbits++; end
      end
      prev_cs = bus.DAC_CS; prev_sck = bus.DAC_SCK; prev_mosi = bus.DAC_MOSI;
      if (!bus.busy) begin period = cyc; break; end
      bus.sample_tick = (cyc == extra_at);
      if (cyc == 1 || cyc == extra_at) rand_inputs();
    end
    bus.sample_tick = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (bus.sample_out !== 16'h8000) begin failures++; $display("FAIL reset_sample_out got=%h exp=8000", bus.sample_out); end
    checks++; if (bus.DAC_CS !== 1'b1) begin failures++; $display("FAIL reset_cs got=%b exp=1", bus.DAC_CS); end
    checks++; if (bus.DAC_SCK !== 1'b0) begin failures++; $display("FAIL reset_sck got=%b exp=0", bus.DAC_SCK); end
    checks++; if (bus.DAC_MOSI !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b exp=0", bus.DAC_MOSI); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun); end
  endtask

  task automatic test_unity;
    logic [23:0] bits; logic [15:0] so; int nb, fa, lc, fl, pd, gl;
    run_frame(16'hC000, 16'h1234, 16'hFFFF, 8'd128, 8'd0, 8'd0, 1'b0, 0, bits, nb, fa, lc, fl, pd, gl, so);
    checks++; if (so !== 16'hC000) begin failures++; $display("FAIL unity_sample got=%h exp=c000", so); end
    checks++; if (bits !== 24'h30C000 || nb != 24) begin failures++; $display("FAIL unity_frame got=%h/%0d exp=30c000/24", bits, nb); end
    checks++; if (fa != 5) begin failures++; $display("FAIL unity_cs_fall_delay got=%0d exp=5", fa); end
    checks++; if (lc != 192) begin failures++; $display("FAIL unity_cs_low_cycles got=%0d exp=192", lc); end
    checks++; if (pd != 205) begin failures++; $display("FAIL unity_period got=%0d exp=205", pd); end
    checks++; if (gl != 0) begin failures++; $display("FAIL unity_mosi_timing got=%0d exp=0", gl); end
    checks++; if (bus.DAC_CS !== 1'b1 || bus.DAC_MOSI !== 1'b0) begin failures++; $display("FAIL unity_idle_lines got=%b%b exp=10", bus.DAC_CS, bus.DAC_MOSI); end
  endtask

  task automatic test_mix_floor;
    logic [23:0] bits; logic [15:0] so; int nb, fa, lc, fl, pd, gl;
    run_frame(16'hA000, 16'h6000, 16'h8000, 8'd64, 8'd128, 8'd255, 1'b0, 0, bits, nb, fa, lc, fl, pd, gl, so);
    checks++; if (so !== 16'h7000) begin failures++; $display("FAIL mix_sample got=%h exp=7000", so); end
    checks++; if (bits !== 24'h307000) begin failures++; $display("FAIL mix_frame got=%h exp=307000", bits); end
    checks++; if (bus.sample_out !== 16'h7000) begin failures++; $display("FAIL mix_sample_hold got=%h exp=7000", bus.sample_out); end
  endtask

  task automatic test_saturation;
    logic [23:0] bits; logic [15:0] so; int nb, fa, lc, fl, pd, gl;
    run_frame(16'hFFFF, 16'hFFFF, 16'hFFFF, 8'd255, 8'd255, 8'd255, 1'b0, 0, bits, nb, fa, lc, fl, pd, gl, so);
    checks++; if (so !== 16'hFFFF || bits !== 24'h30FFFF) begin failures++; $display("FAIL sat_high got=%h/%h exp=ffff/30ffff", so, bits); end
    run_frame(16'h0000, 16'h0000, 16'h0000, 8'd255, 8'd255, 8'd255, 1'b0, 0, bits, nb, fa, lc, fl, pd, gl, so);
    checks++; if (so !== 16'h0000 || bits !== 24'h300000) begin failures++; $display("FAIL sat_low got=%h/%h exp=0000/300000", so, bits); end
  endtask

  task automatic test_mute;
    logic [23:0] bits; logic [15:0] so; int nb, fa, lc, fl, pd, gl;
    run_frame(16'hFFFF, 16'h0000, 16'h0000, 8'd128, 8'd0, 8'd0, 1'b1, 0, bits, nb, fa, lc, fl, pd, gl, so);
    checks++; if (so !== 16'h8000 || bits !== 24'h308000) begin failures++; $display("FAIL mute got=%h/%h exp=8000/308000", so, bits); end
  endtask

  task automatic test_random;
    logic [23:0] bits; logic [15:0] so, exp; int nb, fa, lc, fl, pd, gl;
    logic [15:0] v0, v1, v2; logic [7:0] g0, g1, g2; logic m;
    for (int i = 0; i < 8; i++) begin
      v0 = 16'($urandom); v1 = 16'($urandom); v2 = 16'($urandom);
      g0 = 8'($urandom); g1 = 8'($urandom); g2 = 8'($urandom);
      m = ($urandom_range(0, 7) == 0);
      exp = model_mix(v0, v1, v2, g0, g1, g2, m);
      run_frame(v0, v1, v2, g0, g1, g2, m, 0, bits, nb, fa, lc, fl, pd, gl, so);
      checks++;
      if (so !== exp || bits !== {8'h30, exp} || nb != 24 || gl != 0)
        begin failures++; $display("FAIL random_%0d got=%h/%h/%0d exp=%h/30%h/24", i, so, bits, nb, exp, exp); end
    end
  endtask

  task automatic test_overrun;
    logic [23:0] bits; logic [15:0] so, exp; int nb, fa, lc, fl, pd, gl;
    exp = model_mix(16'h9000, 16'h7000, 16'hC000, 8'd200, 8'd30, 8'd100, 1'b0);
    run_frame(16'h9000, 16'h7000, 16'hC000, 8'd200, 8'd30, 8'd100, 1'b0, 50, bits, nb, fa, lc, fl, pd, gl, so);
    checks++; if (bits !== {8'h30, exp}) begin failures++; $display("FAIL overrun_frame got=%h exp=30%h", bits, exp); end
    checks++; if (fl != 1 || pd != 205) begin failures++; $display("FAIL overrun_single_frame got=%0d/%0d exp=1/205", fl, pd); end
    checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL overrun_flag got=%b exp=1", bus.overrun); end
    exp = model_mix(16'h4321, 16'hBEEF, 16'h8001, 8'd128, 8'd77, 8'd9, 1'b0);
    run_frame(16'h4321, 16'hBEEF, 16'h8001, 8'd128, 8'd77, 8'd9, 1'b0, 0, bits, nb, fa, lc, fl, pd, gl, so);
    checks++; if (bits !== {8'h30, exp}) begin failures++; $display("FAIL overrun_next_frame got=%h exp=30%h", bits, exp); end
    checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%b exp=1", bus.overrun); end
  endtask

  task automatic test_reset_mid;
    logic [23:0] bits; logic [15:0] so, exp; int nb, fa, lc, fl, pd, gl, rises, lows;
    logic prev;
    rises = 0; prev = 1'b0;
    bus.voice0 = 16'hC000; bus.voice1 = 16'h0; bus.voice2 = 16'h0;
    bus.gain0 = 8'd128; bus.gain1 = 8'd0; bus.gain2 = 8'd0; bus.mute = 1'b0;
    bus.sample_tick = 1'b1;
    for (int cyc = 1; cyc <= 400 && rises < 10; cyc++) begin
      @(negedge clk);
      bus.sample_tick = 1'b0;
      if (!prev && bus.DAC_SCK) rises++;
      prev = bus.DAC_SCK;
    end
    checks++; if (rises != 10) begin failures++; $display("FAIL midreset_reach_bit got=%0d exp=10", rises); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.DAC_CS !== 1'b1 || bus.DAC_SCK !== 1'b0) begin failures++; $display("FAIL midreset_lines got=%b%b exp=10", bus.DAC_CS, bus.DAC_SCK); end
    checks++; if (bus.busy !== 1'b0 || bus.overrun !== 1'b0) begin failures++; $display("FAIL midreset_status got=%b%b exp=00", bus.busy, bus.overrun); end
    checks++; if (bus.sample_out !== 16'h8000) begin failures++; $display("FAIL midreset_sample got=%h exp=8000", bus.sample_out); end
    lows = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (bus.DAC_CS !== 1'b1 || bus.busy !== 1'b0) lows++;
    end
    checks++; if (lows != 0) begin failures++; $display("FAIL midreset_abandoned got=%0d exp=0", lows); end
    exp = model_mix(16'h2468, 16'hF00D, 16'h7FFF, 8'd255, 8'd1, 8'd128, 1'b0);
    run_frame(16'h2468, 16'hF00D, 16'h7FFF, 8'd255, 8'd1, 8'd128, 1'b0, 0, bits, nb, fa, lc, fl, pd, gl, so);
    checks++; if (bits !== {8'h30, exp} || lc != 192 || fa != 5) begin failures++; $display("FAIL midreset_next_frame got=%h/%0d/%0d exp=30%h/192/5", bits, lc, fa, exp); end
  endtask

  task automatic test_back_to_back;
    logic [23:0] bits; logic [15:0] so, exp; int nb, fa, lc, fl, pd, gl;
    for (int i = 0; i < 3; i++) begin
      exp = model_mix(16'h8800 + 16'(i), 16'h7000, 16'h9999, 8'd128, 8'd128, 8'd128, 1'b0);
      run_frame(16'h8800 + 16'(i), 16'h7000, 16'h9999, 8'd128, 8'd128, 8'd128, 1'b0, 0, bits, nb, fa, lc, fl, pd, gl, so);
      checks++; if (bits !== {8'h30, exp} || pd != 205) begin failures++; $display("FAIL b2b_%0d got=%h/%0d exp=30%h/205", i, bits, pd, exp); end
    end
    checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL b2b_no_overrun got=%b exp=0", bus.overrun); end
  endtask

  task automatic test_gap_tick;
    logic [23:0] bits; logic [15:0] so, exp; int nb, fa, lc, fl, pd, gl;
    exp = model_mix(16'h1111, 16'hEEEE, 16'h8000, 8'd90, 8'd180, 8'd0, 1'b0);
    run_frame(16'h1111, 16'hEEEE, 16'h8000, 8'd90, 8'd180, 8'd0, 1'b0, 204, bits, nb, fa, lc, fl, pd, gl, so);
    checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL gap_tick_overrun got=%b exp=1", bus.overrun); end
    checks++; if (bits !== {8'h30, exp} || fl != 1) begin failures++; $display("FAIL gap_tick_frame got=%h/%0d exp=30%h/1", bits, fl, exp); end
    repeat (4) @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.DAC_CS !== 1'b1) begin failures++; $display("FAIL gap_tick_ignored got=%b%b exp=01", bus.busy, bus.DAC_CS); end
  endtask

  initial begin
    rst = 1'b1;
    bus.sample_tick = 1'b0;
    rand_inputs();
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_unity();
    test_mix_floor();
    test_saturation();
    test_mute();
    test_random();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    test_gap_tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
